// File: rtl/pzcorebus_1_to_m_switch_order_pkg.sv
// Shared types and helpers for the 1-to-m switch order controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: pzcorebus_order_state FSM encoding, calc_count_width() for counter sizing.
package pzcorebus_1_to_m_switch_order_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } pzcorebus_order_state;

    // Bits needed to hold 0..max_outstanding inclusive.
    function automatic int calc_count_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/pzcorebus_1_to_m_switch_order_controller_if.sv
// Bundle of command gating, response completion and status signals for the order controller.
// Latency: n/a (wires only).
// Backpressure: carries valid/accept pairs; slave = controller side, master = surrounding logic.
// Parameters: PORT_WIDTH (master port index width), COUNT_WIDTH (outstanding counter width).
interface pzcorebus_1_to_m_switch_order_controller_if #(
    parameter int PORT_WIDTH  = 1,
    parameter int COUNT_WIDTH = 4
);
    logic                   scmd_valid;
    logic                   scmd_accept;
    logic [PORT_WIDTH-1:0]  scmd_port;
    logic                   scmd_non_posted;
    logic                   mcmd_valid;
    logic                   mcmd_accept;
    logic                   sresp_valid;
    logic                   sresp_accept;
    logic                   sresp_last;
    logic                   busy;
    logic [PORT_WIDTH-1:0]  current_port;
    logic [COUNT_WIDTH-1:0] outstanding;
    logic                   error;

    modport slave (
        input  scmd_valid, scmd_port, scmd_non_posted, mcmd_accept,
               sresp_valid, sresp_accept, sresp_last,
        output scmd_accept, mcmd_valid, busy, current_port, outstanding, error
    );

    modport master (
        output scmd_valid, scmd_port, scmd_non_posted, mcmd_accept,
               sresp_valid, sresp_accept, sresp_last,
        input  scmd_accept, mcmd_valid, busy, current_port, outstanding, error
    );
endinterface

// File: rtl/pzcorebus_outstanding_counter.sv
// Saturating up/down counter of in-flight requests.
// Latency: count updates on the clock edge after up/down; zero/full/underflow are combinational.
// Backpressure: none; callers gate 'up' with 'full'. 'down' at zero is ignored and flagged.
// Ports: clk, rst (sync, active-high), up, down -> count, zero, full, underflow.
module pzcorebus_outstanding_counter
    import pzcorebus_1_to_m_switch_order_pkg::*;
#(
    parameter int MAX_COUNT = 8,
    parameter int WIDTH     = calc_count_width(MAX_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             full,
    output logic             underflow
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q;
    logic             down_ok;
    logic             inc;
    logic             dec;

    assign zero      = (count_q == '0);
    assign full      = (count_q >= MAX_VAL);
    // A completion with nothing outstanding cannot belong to any tracked request,
    // even if a new request is issued in the same cycle.
    assign underflow = down & zero;
    assign down_ok   = down & ~zero;
    assign inc       = up & ~down_ok & ~full;
    assign dec       = down_ok & ~up;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + WIDTH'(1);
        end else if (dec) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pzcorebus_1_to_m_switch_order_controller.sv
// Holds commands to a new master port until all responses from the current port have returned.
// Latency: 0-cycle combinational gating; state/count update on the edge after the handshake.
// Backpressure: deasserts mcmd_valid and scmd_accept together while the head command must wait.
// Ports: i_clk, i_rst (sync, active-high), bus (slave modport of the controller interface).
// Optional: PZCOREBUS_1_TO_M_SWITCH_ORDER_CONTROLLER_ERROR_CHECK_EN builds the sticky underflow flag.
module pzcorebus_1_to_m_switch_order_controller
    import pzcorebus_1_to_m_switch_order_pkg::*;
#(
    parameter int MASTERS         = 2,
    parameter int PORT_WIDTH      = (MASTERS > 1) ? $clog2(MASTERS) : 1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int COUNT_WIDTH     = calc_count_width(MAX_OUTSTANDING)
) (
    input logic i_clk,
    input logic i_rst,
    pzcorebus_1_to_m_switch_order_controller_if.slave bus
);
    if (MAX_OUTSTANDING < 1 || (MASTERS > 1 && PORT_WIDTH < $clog2(MASTERS))) begin : g_bad_params
        $error("pzcorebus_1_to_m_switch_order_controller: inconsistent parameters");
    end

    pzcorebus_order_state   state_q;
    pzcorebus_order_state   state_d;
    logic [PORT_WIDTH-1:0]  current_port_q;
    logic [COUNT_WIDTH-1:0] count;
    logic                   zero;
    logic                   full;
    logic                   underflow;
    logic                   allow;
    logic                   same_port;
    logic                   cmd_done;
    logic                   resp_done;
    logic                   empty_next;

    assign same_port = (bus.scmd_port == current_port_q);
    assign cmd_done  = bus.scmd_valid & bus.scmd_accept & bus.scmd_non_posted;
    assign resp_done = bus.sresp_valid & bus.sresp_accept & bus.sresp_last;

    // Count will be zero after this edge. A completion at zero is ignored by the counter.
    assign empty_next = ~cmd_done & (zero | ((count == COUNT_WIDTH'(1)) & resp_done));

    pzcorebus_outstanding_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .WIDTH     (COUNT_WIDTH)
    ) u_counter (
        .clk       (i_clk),
        .rst       (i_rst),
        .up        (cmd_done),
        .down      (resp_done),
        .count     (count),
        .zero      (zero),
        .full      (full),
        .underflow (underflow)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        allow   = 1'b0;
        case (state_q)
            IDLE: begin
                allow = 1'b1;
                if (cmd_done) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                allow = same_port & (~bus.scmd_non_posted | ~full);
                // Any valid head command to another port commits to draining, even if the
                // head later changes. If the drain completes on this very edge, skip DRAIN.
                if (bus.scmd_valid & ~same_port) begin
                    state_d = empty_next ? IDLE : DRAIN;
                end else if (empty_next) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (empty_next) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port ownership is only taken when the first non-posted request leaves IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            current_port_q <= '0;
        end else if ((state_q == IDLE) && cmd_done) begin
            current_port_q <= bus.scmd_port;
        end
    end

    assign bus.mcmd_valid   = bus.scmd_valid & allow;
    assign bus.scmd_accept  = bus.mcmd_accept & allow;
    assign bus.busy         = ~zero;
    assign bus.current_port = current_port_q;
    assign bus.outstanding  = count;

`ifdef PZCOREBUS_1_TO_M_SWITCH_ORDER_CONTROLLER_ERROR_CHECK_EN
    logic error_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            error_q <= 1'b0;
        end else if (underflow) begin
            error_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!underflow)
                else $error("pzcorebus_1_to_m_switch_order_controller: response with no outstanding request");
        end
    end

    assign bus.error = error_q;
`else
    logic unused_underflow;
    assign unused_underflow = underflow;
    assign bus.error        = 1'b0;
`endif
endmodule

// File: tb/tb_pzcorebus_1_to_m_switch_order_controller.sv
`timescale 1ns/1ps
module tb_pzcorebus_1_to_m_switch_order_controller;
    import pzcorebus_1_to_m_switch_order_pkg::*;

    localparam int MASTERS = 4;
    localparam int PW      = 2;
    localparam int MAXO    = 8;
    localparam int CW      = 4;
`ifdef PZCOREBUS_1_TO_M_SWITCH_ORDER_CONTROLLER_ERROR_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pzcorebus_1_to_m_switch_order_controller_if #(.PORT_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();

    pzcorebus_1_to_m_switch_order_controller #(
        .MASTERS         (MASTERS),
        .PORT_WIDTH      (PW),
        .MAX_OUTSTANDING (MAXO),
        .COUNT_WIDTH     (CW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [PW-1:0] port;
        logic          np;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted command must match the next expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && bus.scmd_valid && bus.scmd_accept) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept: port %0d accepted at cycle %0d with no expectation",
                         bus.scmd_port, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("accept_port", int'(bus.scmd_port), int'(mon_e.port));
                check("accept_np", int'(bus.scmd_non_posted), int'(mon_e.np));
                check("accept_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a command that is expected to be accepted in the current cycle.
    task automatic push(input int port, input logic np);
        exp_t e;
        e.port = PW'(port);
        e.np   = np;
        e.cyc  = cyc;
        exp_q.push_back(e);
        bus.scmd_valid      = 1'b1;
        bus.scmd_port       = PW'(port);
        bus.scmd_non_posted = np;
    endtask

    // Drive a command that is expected to stall.
    task automatic hold(input int port, input logic np);
        bus.scmd_valid      = 1'b1;
        bus.scmd_port       = PW'(port);
        bus.scmd_non_posted = np;
    endtask

    task automatic idle_cmd();
        bus.scmd_valid = 1'b0;
    endtask

    task automatic resp(input logic v, input logic last);
        bus.sresp_valid = v;
        bus.sresp_last  = last;
    endtask

    task automatic check_status(input string name, input int outst, input int st);
        check({name, "_outstanding"}, int'(bus.outstanding), outst);
        check({name, "_busy"}, int'(bus.busy), (outst != 0) ? 1 : 0);
        check({name, "_state"}, int'(dut.state_q), st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                 = 1'b1;
        bus.scmd_valid      = 1'b0;
        bus.scmd_port       = '0;
        bus.scmd_non_posted = 1'b0;
        bus.mcmd_accept     = 1'b1;
        bus.sresp_valid     = 1'b0;
        bus.sresp_accept    = 1'b1;
        bus.sresp_last      = 1'b0;
        tick();
        tick();

        // Reset state and transparent gating in IDLE
        check_status("reset", 0, int'(IDLE));
        check("reset_current_port", int'(bus.current_port), 0);
        check("reset_error", int'(bus.error), 0);
        bus.mcmd_accept = 1'b0;
        hold(3, 1'b1);
        #1;
        check("reset_mcmd_valid", int'(bus.mcmd_valid), 1);
        check("reset_scmd_accept_lo", int'(bus.scmd_accept), 0);
        bus.mcmd_accept = 1'b1;
        #1;
        check("reset_scmd_accept_hi", int'(bus.scmd_accept), 1);
        idle_cmd();
        #1;
        check("reset_mcmd_valid_lo", int'(bus.mcmd_valid), 0);
        rst = 1'b0;
        tick();

        // Same-port reads: 3 non-posted to port 1
        for (int i = 0; i < 3; i++) begin
            push(1, 1'b1);
            tick();
        end
        idle_cmd();
        check_status("same_port", 3, int'(ACTIVE));
        check("same_port_current", int'(bus.current_port), 1);
        resp(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        resp(1'b0, 1'b0);
        check_status("same_port_drained", 0, int'(IDLE));

        // Port switch with a multi-beat response
        push(0, 1'b1); tick();
        push(0, 1'b1); tick();
        hold(1, 1'b1); tick();
        check_status("switch_stall", 2, int'(DRAIN));
        check("switch_stall_accept", int'(bus.scmd_accept), 0);
        check("switch_stall_mcmd_valid", int'(bus.mcmd_valid), 0);
        resp(1'b1, 1'b0); tick();
        check_status("multibeat_nolast", 2, int'(DRAIN));
        resp(1'b1, 1'b1); tick();
        check_status("switch_one_left", 1, int'(DRAIN));
        tick();
        resp(1'b0, 1'b0);
        check_status("switch_drained", 0, int'(IDLE));
        push(1, 1'b1); tick();
        idle_cmd();
        check("switch_new_port", int'(bus.current_port), 1);
        check_status("switch_new", 1, int'(ACTIVE));
        resp(1'b1, 1'b1); tick();
        resp(1'b0, 1'b0);
        check_status("switch_done", 0, int'(IDLE));

        // Outstanding limit
        for (int i = 0; i < MAXO; i++) begin
            push(0, 1'b1);
            tick();
        end
        idle_cmd();
        check_status("limit_full", 8, int'(ACTIVE));
        hold(0, 1'b1); tick();
        check("limit_stall_accept", int'(bus.scmd_accept), 0);
        check_status("limit_stall", 8, int'(ACTIVE));
        resp(1'b1, 1'b1); tick();
        resp(1'b0, 1'b0);
        check_status("limit_dropped", 7, int'(ACTIVE));
        push(0, 1'b1); tick();
        idle_cmd();
        check_status("limit_refill", 8, int'(ACTIVE));
        resp(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        resp(1'b0, 1'b0);
        check_status("limit_four", 4, int'(ACTIVE));

        // Simultaneous issue and completion at count 4
        push(0, 1'b1);
        resp(1'b1, 1'b1);
        tick();
        idle_cmd();
        resp(1'b0, 1'b0);
        check_status("simul", 4, int'(ACTIVE));
        resp(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        resp(1'b0, 1'b0);
        check_status("simul_drained", 0, int'(IDLE));

        // Posted write to another port while a read is outstanding
        push(0, 1'b1); tick();
        hold(2, 1'b0); tick();
        check_status("posted_stall", 1, int'(DRAIN));
        check("posted_stall_accept", int'(bus.scmd_accept), 0);
        resp(1'b1, 1'b1); tick();
        resp(1'b0, 1'b0);
        check_status("posted_drained", 0, int'(IDLE));
        push(2, 1'b0); tick();
        push(3, 1'b0); tick();
        push(1, 1'b0); tick();
        idle_cmd();
        check_status("posted_idle", 0, int'(IDLE));
        check("posted_keeps_port", int'(bus.current_port), 0);

        // Underflow
        resp(1'b1, 1'b1); tick();
        resp(1'b0, 1'b0);
        check_status("underflow", 0, int'(IDLE));
        check("underflow_error", int'(bus.error), EXP_ERR);

        // Reset in the middle of a drain
        push(2, 1'b1); tick();
        hold(3, 1'b1); tick();
        check_status("pre_reset", 1, int'(DRAIN));
        check("pre_reset_port", int'(bus.current_port), 2);
        rst = 1'b1;
        tick();
        check_status("mid_reset", 0, int'(IDLE));
        check("mid_reset_port", int'(bus.current_port), 0);
        check("mid_reset_error", int'(bus.error), 0);
        check("mid_reset_mcmd_valid", int'(bus.mcmd_valid), 1);
        check("mid_reset_scmd_accept", int'(bus.scmd_accept), 1);
        idle_cmd();
        rst = 1'b0;
        tick();
        tick();

        check("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
